// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the issue scheduler slice.
//   stage_rec_t   : per-stage record {valid, dest, write, load, branch}
//   sched_state_t : issue state machine encoding (RUN / FLUSH)
//   FWD_*         : operand forwarding select encodings
// Stage records carry destinations zero-extended to REC_ADDR_W bits, so any
// register-file address width up to REC_ADDR_W shares one record type.
package issue_pkg;

  localparam int REC_ADDR_W = 8;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REC_ADDR_W-1:0] dest;
    logic                  write;
    logic                  load;
    logic                  branch;
  } stage_rec_t;

endpackage

// File: rtl/issue_scheduler_if.sv
// Decoder-to-scheduler issue bus.
//   master : decoder side, presents a decoded instruction and sees inReady
//   slave  : scheduler side, consumes the instruction and drives inReady
// Signals: inValid/inReady handshake, two source operands with used flags,
// destination with write flag, and load/branch class bits.
interface issue_scheduler_if #(
  parameter int ADDR_W = 5
);
  logic              inValid;
  logic              inReady;
  logic [ADDR_W-1:0] srcAAddr;
  logic              srcAUsed;
  logic [ADDR_W-1:0] srcBAddr;
  logic              srcBUsed;
  logic [ADDR_W-1:0] destAddr;
  logic              destWrite;
  logic              isLoad;
  logic              isBranch;

  modport master (
    output inValid, srcAAddr, srcAUsed, srcBAddr, srcBUsed,
           destAddr, destWrite, isLoad, isBranch,
    input  inReady
  );

  modport slave (
    input  inValid, srcAAddr, srcAUsed, srcBAddr, srcBUsed,
           destAddr, destWrite, isLoad, isBranch,
    output inReady
  );
endinterface

// File: rtl/issue_scheduler_hazard_match.sv
// Combinational dependency check of one pipeline stage against one source.
//   valid/write/dest : fields of the stage record being compared
//   src/used         : source register address and its register-file read flag
//   match            : stage will produce the value this source needs
// Register 0 is hard-wired zero, so it never matches.
module hazard_match
  import issue_pkg::*;
(
  input  logic                  valid,
  input  logic                  write,
  input  logic [REC_ADDR_W-1:0] dest,
  input  logic [REC_ADDR_W-1:0] src,
  input  logic                  used,
  output logic                  match
);

  assign match = valid && write && used && (src != '0) && (dest == src);

endmodule

// File: rtl/issue_scheduler.sv
// Issue/hazard controller between the decoder and the execute stage.
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   dec           : decoder issue bus (slave side, drives inReady)
//   branchTaken   : ALU compare result, only meaningful for a branch in EX
//   issueValid    : EX holds a real instruction
//   fwdSelA/B     : registered operand sources (0 RF, 1 EX/MEM, 2 MEM/WB)
//   flush         : taken branch resolving in EX this cycle
//   stallCount    : saturating count of load-use stall cycles
//   flushCount    : saturating count of taken-branch flushes
// Tracks EX/MEM/WB destination records, inserts a bubble when an instruction
// needs a load result still in EX, and squashes issue after taken branches.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  issue_scheduler_if.slave    dec,
  input  logic                branchTaken,
  output logic                issueValid,
  output logic [1:0]          fwdSelA,
  output logic [1:0]          fwdSelB,
  output logic                flush,
  output logic [CNT_W-1:0]    stallCount,
  output logic [CNT_W-1:0]    flushCount
);

  localparam int PAD_W = REC_ADDR_W - ADDR_W;

  stage_rec_t   exRec, memRec, wbRec, exNext;
  sched_state_t state, stateNext;
  logic [2:0]   flushCnt, flushCntNext;
  logic [1:0]   fwdANext, fwdBNext;

  logic [REC_ADDR_W-1:0] srcAExt, srcBExt, destExt;
  logic exMatchA, exMatchB, memMatchA, memMatchB;
  logic loadHazard, accept;

  // WB and the class bits of MEM are tracked for completeness of the stage
  // records but no longer influence forwarding decisions.
  logic unusedStageBits;
  assign unusedStageBits = ^{wbRec, memRec.load, memRec.branch};

  assign srcAExt = {{PAD_W{1'b0}}, dec.srcAAddr};
  assign srcBExt = {{PAD_W{1'b0}}, dec.srcBAddr};
  assign destExt = {{PAD_W{1'b0}}, dec.destAddr};

  hazard_match uExA (
    .valid(exRec.valid), .write(exRec.write), .dest(exRec.dest),
    .src(srcAExt), .used(dec.srcAUsed), .match(exMatchA)
  );

  hazard_match uExB (
    .valid(exRec.valid), .write(exRec.write), .dest(exRec.dest),
    .src(srcBExt), .used(dec.srcBUsed), .match(exMatchB)
  );

  hazard_match uMemA (
    .valid(memRec.valid), .write(memRec.write), .dest(memRec.dest),
    .src(srcAExt), .used(dec.srcAUsed), .match(memMatchA)
  );

  hazard_match uMemB (
    .valid(memRec.valid), .write(memRec.write), .dest(memRec.dest),
    .src(srcBExt), .used(dec.srcBUsed), .match(memMatchB)
  );

  // A load result is not available until MEM, so a consumer directly behind
  // a load must wait one cycle.
  assign loadHazard  = dec.inValid && exRec.load && (exMatchA || exMatchB);
  assign flush       = (state == RUN) && exRec.valid && exRec.branch && branchTaken;
  assign dec.inReady = (state == RUN) && !flush && !loadHazard;
  assign accept      = dec.inValid && dec.inReady;
  assign issueValid  = exRec.valid;

  // The flush cycle itself is the first bubble; FLUSH covers the remaining
  // FLUSH_CYCLES-1 bubbles.
  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    case (state)
      RUN: begin
        if (flush && (FLUSH_CYCLES > 1)) begin
          stateNext    = FLUSH;
          flushCntNext = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flushCntNext = flushCnt - 3'd1;
        if (flushCnt <= 3'd1) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext    = RUN;
        flushCntNext = 3'd0;
      end
    endcase
  end

  // EX priority: the youngest producer holds the newest value of a register.
  always_comb begin
    exNext   = '0;
    fwdANext = FWD_RF;
    fwdBNext = FWD_RF;
    if (accept) begin
      exNext.valid  = 1'b1;
      exNext.dest   = destExt;
      exNext.write  = dec.destWrite;
      exNext.load   = dec.isLoad;
      exNext.branch = dec.isBranch;
      fwdANext = exMatchA ? FWD_EXMEM : (memMatchA ? FWD_MEMWB : FWD_RF);
      fwdBNext = exMatchB ? FWD_EXMEM : (memMatchB ? FWD_MEMWB : FWD_RF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      flushCnt <= 3'd0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exRec   <= '0;
      memRec  <= '0;
      wbRec   <= '0;
      fwdSelA <= FWD_RF;
      fwdSelB <= FWD_RF;
    end else begin
      wbRec   <= memRec;
      memRec  <= exRec;
      exRec   <= exNext;
      fwdSelA <= fwdANext;
      fwdSelB <= fwdBNext;
    end
  end

  // A flush outranks a coincident load-use hazard: the dependent instruction
  // is on the wrong path, so that cycle is not counted as a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (loadHazard && !flush && (stallCount != '1)) begin
        stallCount <= stallCount + CNT_W'(1);
      end
      if (flush && (flushCount != '1)) begin
        flushCount <= flushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler.
// DUT configured with ADDR_W=5, FLUSH_CYCLES=2, CNT_W=2 so both counters
// can be driven into saturation within a short run.
module tb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       branchTaken = 1'b0;
  logic       issueValid;
  logic [1:0] fwdSelA;
  logic [1:0] fwdSelB;
  logic       flush;
  logic [1:0] stallCount;
  logic [1:0] flushCount;

  int total = 0;
  int bad   = 0;
  logic [1:0] stallExp;
  logic [1:0] flushExp;

  issue_scheduler_if #(.ADDR_W(5)) dec ();

  issue_scheduler #(
    .ADDR_W(5),
    .FLUSH_CYCLES(2),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dec(dec),
    .branchTaken(branchTaken),
    .issueValid(issueValid),
    .fwdSelA(fwdSelA),
    .fwdSelB(fwdSelB),
    .flush(flush),
    .stallCount(stallCount),
    .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [4:0] sa, input logic ua,
                               input logic [4:0] sb, input logic ub, input logic [4:0] d,
                               input logic w, input logic ld, input logic br);
    dec.inValid   = v;
    dec.srcAAddr  = sa;
    dec.srcAUsed  = ua;
    dec.srcBAddr  = sb;
    dec.srcBUsed  = ub;
    dec.destAddr  = d;
    dec.destWrite = w;
    dec.isLoad    = ld;
    dec.isBranch  = br;
  endtask

  task automatic aluOp(input logic [4:0] d, input logic [4:0] sa, input logic [4:0] sb);
    applyStimulus(1'b1, sa, 1'b1, sb, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic loadOp(input logic [4:0] d, input logic [4:0] sa);
    applyStimulus(1'b1, sa, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic branchOp();
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idleOp();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    idleOp();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_issueValid", issueValid, 0);
    checkOutput("rst_fwdA", fwdSelA, 0);
    checkOutput("rst_fwdB", fwdSelB, 0);
    checkOutput("rst_stallCount", stallCount, 0);
    checkOutput("rst_flushCount", flushCount, 0);
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_inReady", dec.inReady, 1);

    // Reset asserted mid-stream drops the in-flight producer of r3
    aluOp(5'd3, 5'd1, 5'd2);
    #1;
    checkOutput("mid_inReady", dec.inReady, 1);
    cycle();
    checkOutput("mid_issue", issueValid, 1);
    aluOp(5'd4, 5'd3, 5'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_issueValid", issueValid, 0);
    cycle();
    rst_n = 1'b1;
    #1;
    checkOutput("release_inReady", dec.inReady, 1);
    checkOutput("release_issueValid", issueValid, 0);
    cycle();
    checkOutput("post_rst_issue", issueValid, 1);
    checkOutput("post_rst_fwdA", fwdSelA, 0);
    checkOutput("post_rst_fwdB", fwdSelB, 0);

    // Forwarding: EX=r4, MEM=empty
    aluOp(5'd3, 5'd1, 5'd2);
    cycle();
    checkOutput("fwd_none_A", fwdSelA, 0);
    checkOutput("fwd_none_B", fwdSelB, 0);
    aluOp(5'd4, 5'd3, 5'd5);
    cycle();
    checkOutput("fwd_ex_A", fwdSelA, 1);
    checkOutput("fwd_ex_B", fwdSelB, 0);
    aluOp(5'd6, 5'd2, 5'd3);
    cycle();
    checkOutput("fwd_mem_A", fwdSelA, 0);
    checkOutput("fwd_mem_B", fwdSelB, 2);
    aluOp(5'd6, 5'd4, 5'd1);
    cycle();
    checkOutput("fwd_mem2_A", fwdSelA, 2);
    checkOutput("fwd_mem2_B", fwdSelB, 0);
    aluOp(5'd8, 5'd6, 5'd6);
    cycle();
    checkOutput("fwd_prio_A", fwdSelA, 1);
    checkOutput("fwd_prio_B", fwdSelB, 1);
    aluOp(5'd0, 5'd1, 5'd2);
    cycle();
    aluOp(5'd9, 5'd0, 5'd8);
    cycle();
    checkOutput("fwd_r0_A", fwdSelA, 0);
    checkOutput("fwd_r0_B", fwdSelB, 2);
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("fwd_unused_A", fwdSelA, 0);
    checkOutput("fwd_used_B", fwdSelB, 1);

    // Load-use stall
    loadOp(5'd7, 5'd1);
    #1;
    checkOutput("lu_load_ready", dec.inReady, 1);
    cycle();
    aluOp(5'd8, 5'd7, 5'd1);
    #1;
    checkOutput("lu_stall_ready", dec.inReady, 0);
    checkOutput("lu_stall_flush", flush, 0);
    cycle();
    checkOutput("lu_stallCount", stallCount, 1);
    checkOutput("lu_bubble", issueValid, 0);
    checkOutput("lu_resume_ready", dec.inReady, 1);
    cycle();
    checkOutput("lu_issue", issueValid, 1);
    checkOutput("lu_fwdA", fwdSelA, 2);
    checkOutput("lu_fwdB", fwdSelB, 0);
    checkOutput("lu_stallCount_hold", stallCount, 1);

    // Taken branch with two bubbles
    branchOp();
    cycle();
    checkOutput("br_in_ex", issueValid, 1);
    aluOp(5'd11, 5'd1, 5'd2);
    branchTaken = 1'b1;
    #1;
    checkOutput("br_flush", flush, 1);
    checkOutput("br_ready0", dec.inReady, 0);
    cycle();
    checkOutput("br_flush_once", flush, 0);
    checkOutput("br_ready1", dec.inReady, 0);
    checkOutput("br_bubble1", issueValid, 0);
    checkOutput("br_flushCount", flushCount, 1);
    cycle();
    checkOutput("br_ready_back", dec.inReady, 1);
    checkOutput("br_bubble2", issueValid, 0);
    checkOutput("br_no_reflush", flush, 0);
    branchTaken = 1'b0;
    cycle();
    checkOutput("br_resume", issueValid, 1);

    // Not-taken branch, branchTaken on a bubble, branchTaken on a non-branch
    branchOp();
    cycle();
    idleOp();
    #1;
    checkOutput("nt_flush", flush, 0);
    checkOutput("nt_ready", dec.inReady, 1);
    cycle();
    branchTaken = 1'b1;
    #1;
    checkOutput("bubble_bt_flush", flush, 0);
    aluOp(5'd12, 5'd1, 5'd2);
    branchTaken = 1'b0;
    cycle();
    idleOp();
    branchTaken = 1'b1;
    #1;
    checkOutput("nonbr_bt_flush", flush, 0);
    checkOutput("nonbr_bt_ready", dec.inReady, 1);
    cycle();
    branchTaken = 1'b0;
    checkOutput("nt_flushCount", flushCount, 1);
    checkOutput("nt_stallCount", stallCount, 1);

    // Load-use coincident with a taken branch: flush wins
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
    cycle();
    aluOp(5'd8, 5'd7, 5'd1);
    branchTaken = 1'b1;
    #1;
    checkOutput("prio_flush", flush, 1);
    checkOutput("prio_ready", dec.inReady, 0);
    cycle();
    checkOutput("prio_stallCount", stallCount, 1);
    checkOutput("prio_flushCount", flushCount, 2);
    checkOutput("prio_ready_flush", dec.inReady, 0);
    branchTaken = 1'b0;
    cycle();
    checkOutput("prio_ready_back", dec.inReady, 1);
    cycle();
    checkOutput("prio_issue", issueValid, 1);
    checkOutput("prio_fwdA", fwdSelA, 0);

    // Five more load-use stalls saturate the 2-bit stall counter
    stallExp = 2'd1;
    for (int i = 0; i < 5; i++) begin
      loadOp(5'd7, 5'd1);
      cycle();
      aluOp(5'd8, 5'd7, 5'd1);
      #1;
      checkOutput("sat_stall_ready", dec.inReady, 0);
      cycle();
      stallExp = (stallExp == 2'd3) ? 2'd3 : stallExp + 2'd1;
      checkOutput("sat_stallCount", stallCount, 32'(stallExp));
      cycle();
    end
    checkOutput("sat_stall_final", stallCount, 3);

    // Two more taken branches saturate the flush counter
    flushExp = 2'd2;
    for (int i = 0; i < 2; i++) begin
      branchOp();
      cycle();
      idleOp();
      branchTaken = 1'b1;
      #1;
      checkOutput("sat_flush", flush, 1);
      cycle();
      branchTaken = 1'b0;
      flushExp = (flushExp == 2'd3) ? 2'd3 : flushExp + 2'd1;
      checkOutput("sat_flushCount", flushCount, 32'(flushExp));
      cycle();
    end
    checkOutput("sat_flush_final", flushCount, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue/hazard controller between the instruction decoder and the execute stage (datapath controller, ALU source select, ALU).
- Tracks destination registers of in-flight instructions in EX/MEM/WB and inserts load-use stall bubbles.
- Generates registered forwarding selects for both ALU operands.
- Squashes wrong-path issue for FLUSH_CYCLES cycles after a taken branch resolves in EX.

Parameters:
- ADDR_W, 5, register-file address width; register 0 is hard-wired zero and never creates a hazard.
- FLUSH_CYCLES, 2, bubbles inserted after a taken branch (1..7).
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  decoded instruction presented
- inReady  out  1  scheduler accepts the presented instruction this cycle
- srcAAddr  in  ADDR_W  operand A source register
- srcAUsed  in  1  operand A reads the register file
- srcBAddr  in  ADDR_W  operand B source register
- srcBUsed  in  1  operand B reads the register file
- destAddr  in  ADDR_W  destination register
- destWrite  in  1  instruction writes the register file
- isLoad  in  1  instruction is a memory load
- isBranch  in  1  instruction is a conditional branch
- branchTaken  in  1  ALU compare result; sampled only while EX holds a valid branch
- issueValid  out  1  EX stage holds a valid (non-bubble) instruction
- fwdSelA  out  2  operand A source: 0 register file, 1 EX/MEM result, 2 MEM/WB result
- fwdSelB  out  2  operand B source, same encoding
- flush  out  1  taken branch resolving this cycle
- stallCount  out  CNT_W  load-use stall cycles since reset, saturating
- flushCount  out  CNT_W  taken-branch flush events since reset, saturating

Behaviour:
- Reset (asynchronous, rst_n=0):
  - EX/MEM/WB stage records cleared (valid=0).
  - State is RUN and the flush counter is 0.
  - issueValid=0, fwdSelA=fwdSelB=0, stallCount=flushCount=0.
  - flush is 0 because EX is empty; inReady=1 in the first cycle after release.
  - Reset mid-operation discards all in-flight records immediately.
- Stage record contents: {valid, dest, write, load, branch}. Every clock, WB<=MEM and MEM<=EX. EX<=accepted instruction, otherwise a bubble (valid=0).
- Match rule: a stage matches source s iff the stage is valid, its write bit is set, dest==s, s!=0, and the source's Used bit is set.
- loadHazard (combinational): EX.load and EX matches srcA or srcB, qualified by inValid.
- flush (combinational): state==RUN && EX.valid && EX.branch && branchTaken.
- inReady (combinational): state==RUN && !flush && !loadHazard.
- Accept: inValid && inReady; the instruction enters EX on the next edge with latency 1. A stalled instruction must be held stable by the producer.
- fwdSel (registered with the issue): computed against the current EX and MEM records.
  - EX match gives 1; else MEM match gives 2; else 0. EX has priority when both match.
  - Value 0 is driven when no instruction is accepted.
- State machine:
  - RUN: on flush, go to FLUSH with flushCnt=FLUSH_CYCLES-1 and increment flushCount. If FLUSH_CYCLES==1, stay in RUN; the flush cycle itself is the only bubble.
  - FLUSH: inReady=0 and bubbles are issued. Decrement flushCnt each cycle; at 0, return to RUN.
- Simultaneous flush and loadHazard: flush wins and stallCount does not increment.
- stallCount increments once per cycle in which loadHazard is true and flush is false.
- Both counters saturate at all-ones with no wrap-around.
- branchTaken is ignored when EX is a bubble or holds a non-branch.

Decomposition:
- Shared package issue_pkg:
  - stage_rec_t struct {valid, dest[ADDR_W], write, load, branch}.
  - Enum sched_state_t {RUN, FLUSH}.
  - FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
- One sub-module, hazard_match: combinational comparison of one stage record against one source. Instantiated 4 times (EX/MEM x A/B). The top level holds the stage pipeline, FSM and counters.

Test Plan:
- Reset: hold rst_n=0 mid-stream, release -> all outputs 0, inReady=1, next issue has fwdSel 0/0.
- Back-to-back ALU forward:
  - Issue r3<=r1+r2, then r4<=r3+r5 -> second issue has fwdSelA=1, fwdSelB=0.
  - A third instruction reading r3 -> fwdSel=2.
  - An instruction reading r0 after a write to r0 -> fwdSel=0.
- Load-use: issue load r7, then add r8<=r7+r1 -> inReady=0 for exactly 1 cycle, stallCount=1, then the add issues with fwdSelA=2.
- Taken branch, FLUSH_CYCLES=2: branch in EX with branchTaken=1 -> flush=1 for one cycle, inReady=0 for 2 cycles, flushCount=1, issueValid=0 for 2 cycles.
- Branch not taken, and branchTaken=1 while EX is a bubble -> no flush, no stall, counters unchanged.
- Saturation and priority (CNT_W=2): force 5 load-use stalls -> stallCount=3. A load-use hazard coincident with a taken branch -> flush only, stallCount unchanged.
